npu_lane_engine: RTL and testbench

- Parametrised successor to the fixed two-MAC NPU datapath.
- NUM_LANES signed MAC lanes, bias preload, shift/saturate, per-lane ReLU bypass, running argmax and an output FIFO.
- An internal sequencer FSM replaces externally driven control words. Operands arrive over a valid/ready stream.
- Sits between the host operand feeder and the MNIST classifier readout path.

---
 rtl/npu_lane_engine.sv | 166 ++++++++++++++++
 tb/tb_npu_lane_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/npu_lane_engine.sv
// npu_lane_engine: parallel signed MAC lanes with bias, shift/saturate, ReLU, argmax and output FIFO
module npu_lane_engine #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 16,
  parameter int LEN_W      = 10,
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                           CLKEXT,
  input  logic                           RST_N,
  input  logic                           START,
  input  logic [LEN_W-1:0]               CFG_LEN,
  input  logic [4:0]                     CFG_SHIFT,
  input  logic [NUM_LANES-1:0]           CFG_RELU_BYP,
  input  logic [NUM_LANES*OUT_W-1:0]     BIAS,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [NUM_LANES*DATA_W-1:0]    IN_A,
  input  logic [NUM_LANES*DATA_W-1:0]    IN_B,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [OUT_W-1:0]               OUT_DATA,
  output logic [$clog2(FIFO_DEPTH):0]    FIFO_LEVEL,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           ERR_LEN,
  input  logic                           ARGMAX_CLR,
  output logic                           ARGMAX_VLD,
  output logic [OUT_W-1:0]               ARGMAX_VAL,
  output logic [IDX_W-1:0]               ARGMAX_IDX
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LP_W = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);
  typedef enum logic [1:0] {IDLE, ACCUM, POST, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [4:0] shift_q, shift_d;
  logic [NUM_LANES-1:0] byp_q, byp_d;
  logic signed [ACC_W-1:0] acc_q [NUM_LANES];
  logic signed [ACC_W-1:0] acc_d [NUM_LANES];
  logic signed [ACC_W-1:0] sh [NUM_LANES];
  logic signed [2*DATA_W-1:0] prod [NUM_LANES];
  logic signed [OUT_W-1:0] sat [NUM_LANES];
  logic signed [OUT_W-1:0] res_q [NUM_LANES];
  logic signed [OUT_W-1:0] res_d [NUM_LANES];
  logic [LP_W-1:0] lane_q, lane_d;
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] lvl_q, lvl_d;
  logic done_q, done_d, err_q, err_d;
  logic amx_vld_q, amx_vld_d;
  logic signed [OUT_W-1:0] amx_val_q, amx_val_d, push_val;
  logic [IDX_W-1:0] amx_idx_q, amx_idx_d, elem_q, elem_d;
  logic start_ok, hs, last_beat, full, push, pop, last_lane, upd;
  // state register
  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = start_ok ? ACCUM : IDLE;
      ACCUM: state_d = last_beat ? POST : ACCUM;
      POST:  state_d = DRAIN;
      DRAIN: state_d = (push && last_lane) ? IDLE : DRAIN;
    endcase
  end
  // FSM-derived strobes and port outputs
  always_comb begin
    start_ok   = state_q == IDLE && START && CFG_LEN != '0;
    hs         = state_q == ACCUM && IN_VALID;
    last_beat  = hs && cnt_q == len_q - LEN_W'(1);
    full       = lvl_q == (AW+1)'(FIFO_DEPTH);
    push       = state_q == DRAIN && !full;
    pop        = lvl_q != '0 && OUT_READY;
    last_lane  = lane_q == LP_W'(NUM_LANES - 1);
    push_val   = res_q[lane_q];
    IN_READY   = state_q == ACCUM;
    BUSY       = state_q != IDLE;
    OUT_VALID  = lvl_q != '0;
    OUT_DATA   = OUT_VALID ? mem_q[rd_q] : '0;
    FIFO_LEVEL = lvl_q;
    DONE       = done_q;
    ERR_LEN    = err_q;
    ARGMAX_VLD = amx_vld_q;
    ARGMAX_VAL = amx_val_q;
    ARGMAX_IDX = amx_idx_q;
  end
  // lane arithmetic, config latch, FIFO pointers and argmax tracking
  always_comb begin
    len_d   = start_ok ? CFG_LEN : len_q;
    shift_d = start_ok ? CFG_SHIFT : shift_q;
    byp_d   = start_ok ? CFG_RELU_BYP : byp_q;
    cnt_d   = start_ok ? '0 : hs ? cnt_q + LEN_W'(1) : cnt_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      prod[k]  = $signed(IN_A[k*DATA_W +: DATA_W]) * $signed(IN_B[k*DATA_W +: DATA_W]);
      acc_d[k] = start_ok ? ACC_W'($signed(BIAS[k*OUT_W +: OUT_W])) : hs ? acc_q[k] + ACC_W'(prod[k]) : acc_q[k];
      sh[k]    = acc_q[k] >>> shift_q;
      sat[k]   = OUT_W'(sh[k] > SMAX ? SMAX : sh[k] < SMIN ? SMIN : sh[k]);
      res_d[k] = state_q != POST ? res_q[k] : (!byp_q[k] && sat[k][OUT_W-1]) ? '0 : sat[k];
    end
    lane_d    = state_q == POST ? '0 : push ? lane_q + LP_W'(1) : lane_q;
    wr_d      = push ? wr_q + AW'(1) : wr_q;
    rd_d      = pop ? rd_q + AW'(1) : rd_q;
    lvl_d     = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    done_d    = push && last_lane;
    err_d     = state_q == IDLE && START && CFG_LEN == '0;
    upd       = push && (ARGMAX_CLR || !amx_vld_q || push_val > amx_val_q);
    elem_d    = ARGMAX_CLR ? IDX_W'(push) : push ? elem_q + IDX_W'(1) : elem_q;
    amx_vld_d = upd ? 1'b1 : ARGMAX_CLR ? 1'b0 : amx_vld_q;
    amx_val_d = upd ? push_val : ARGMAX_CLR ? '0 : amx_val_q;
    amx_idx_d = upd ? (ARGMAX_CLR ? '0 : elem_q) : ARGMAX_CLR ? '0 : amx_idx_q;
  end
  // datapath and control registers
  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      len_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      byp_q     <= '0;
      lane_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      amx_vld_q <= 1'b0;
      amx_val_q <= '0;
      amx_idx_q <= '0;
      elem_q    <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      byp_q     <= byp_d;
      lane_q    <= lane_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lvl_q     <= lvl_d;
      done_q    <= done_d;
      err_q     <= err_d;
      amx_vld_q <= amx_vld_d;
      amx_val_q <= amx_val_d;
      amx_idx_q <= amx_idx_d;
      elem_q    <= elem_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        acc_q[k] <= acc_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end
  // FIFO storage; contents are only observable through valid pointers
  always_ff @(posedge CLKEXT) begin
    if (push) mem_q[wr_q] <= push_val;
  end
endmodule

// File: tb/tb_npu_lane_engine.sv
// tb_npu_lane_engine: directed self-checking bench for npu_lane_engine
module tb_npu_lane_engine;
  logic CLKEXT = 1'b0;
  logic RST_N, START, IN_VALID, IN_READY, OUT_VALID, OUT_READY, BUSY, DONE, ERR_LEN;
  logic ARGMAX_CLR, ARGMAX_VLD;
  logic [9:0] CFG_LEN;
  logic [4:0] CFG_SHIFT;
  logic [3:0] CFG_RELU_BYP;
  logic [63:0] BIAS;
  logic [31:0] IN_A, IN_B;
  logic [15:0] OUT_DATA, ARGMAX_VAL;
  logic [2:0] FIFO_LEVEL;
  logic [7:0] ARGMAX_IDX;
  int errors = 0;
  int checks = 0;
  int lat;
  logic seen;

  npu_lane_engine #(.FIFO_DEPTH(4)) dut (
    .CLKEXT(CLKEXT), .RST_N(RST_N), .START(START), .CFG_LEN(CFG_LEN),
    .CFG_SHIFT(CFG_SHIFT), .CFG_RELU_BYP(CFG_RELU_BYP), .BIAS(BIAS),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .FIFO_LEVEL(FIFO_LEVEL), .BUSY(BUSY), .DONE(DONE), .ERR_LEN(ERR_LEN),
    .ARGMAX_CLR(ARGMAX_CLR), .ARGMAX_VLD(ARGMAX_VLD), .ARGMAX_VAL(ARGMAX_VAL),
    .ARGMAX_IDX(ARGMAX_IDX)
  );

  always #5 CLKEXT = ~CLKEXT;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic launch(input int len, input int shift, input logic [3:0] byp,
                        input logic [63:0] bias, input logic [31:0] a, input logic [31:0] b);
    CFG_LEN = 10'(len);
    CFG_SHIFT = 5'(shift);
    CFG_RELU_BYP = byp;
    BIAS = bias;
    IN_A = a;
    IN_B = b;
    IN_VALID = 1'b1;
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic wait_done(input int clr_at, output int n);
    logic s;
    s = 1'b0;
    n = 1;
    for (int i = 0; i < 100 && !s; i++) begin
      ARGMAX_CLR = (n == clr_at);
      step();
      n++;
      s = DONE;
    end
    ARGMAX_CLR = 1'b0;
    IN_VALID = 1'b0;
    chk("done_seen", s, 1);
  endtask

  task automatic pop(input int exp);
    chk("pop_valid", OUT_VALID, 1);
    chk("pop_data", int'($signed(OUT_DATA)), exp);
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
  endtask

  task automatic pop4(input int e0, input int e1, input int e2, input int e3);
    pop(e0);
    pop(e1);
    pop(e2);
    pop(e3);
    chk("fifo_empty", FIFO_LEVEL, 0);
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    ARGMAX_CLR = 1'b0;
    CFG_LEN = '0;
    CFG_SHIFT = '0;
    CFG_RELU_BYP = '0;
    BIAS = '0;
    IN_A = '0;
    IN_B = '0;
    #22;
    chk("rst_busy", BUSY, 0);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR_LEN, 0);
    chk("rst_amx_vld", ARGMAX_VLD, 0);
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_out_data", OUT_DATA, 0);
    step();
    RST_N = 1'b1;
    step();

    // bias on lane3, 3 beats of 2*3
    launch(3, 0, 4'h0, 64'h000A_0000_0000_0000, 32'h02020202, 32'h03030303);
    wait_done(0, lat);
    chk("lat_len3", lat, 9);
    chk("level_full", FIFO_LEVEL, 4);
    chk("amx_val_28", int'($signed(ARGMAX_VAL)), 28);
    chk("amx_idx_3", ARGMAX_IDX, 3);
    chk("head_18", OUT_DATA, 18);

    // reset in the middle of accumulation
    launch(8, 0, 4'h0, 64'h0, 32'h01010101, 32'h01010101);
    repeat (3) step();
    chk("mid_busy", BUSY, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_ready", IN_READY, 0);
    chk("mid_rst_level", FIFO_LEVEL, 0);
    chk("mid_rst_amx", ARGMAX_VLD, 0);
    IN_VALID = 1'b0;
    step();
    RST_N = 1'b1;
    step();
    launch(2, 0, 4'h0, 64'h0, 32'h01010101, 32'h01010101);
    wait_done(0, lat);
    chk("lat_len2", lat, 8);
    pop4(2, 2, 2, 2);

    // ReLU, bypass, saturation and shift
    launch(1, 0, 4'b0000, 64'h0, 32'h00807FFC, 32'h007F7F05);
    wait_done(0, lat);
    pop4(0, 16129, 0, 0);
    launch(1, 0, 4'b0001, 64'h0, 32'h00807FFC, 32'h007F7F05);
    wait_done(0, lat);
    pop4(-20, 16129, 0, 0);
    launch(4, 0, 4'b0101, 64'h0, 32'h00807FFC, 32'h007F7F05);
    wait_done(0, lat);
    chk("lat_len4", lat, 10);
    pop4(-80, 32767, -32768, 0);
    launch(4, 2, 4'b0101, 64'h0, 32'h00807FFC, 32'h007F7F05);
    wait_done(0, lat);
    pop4(-20, 16129, -16256, 0);

    // argmax clear, ties keep first index
    ARGMAX_CLR = 1'b1;
    step();
    ARGMAX_CLR = 1'b0;
    chk("clr_vld", ARGMAX_VLD, 0);
    chk("clr_val", ARGMAX_VAL, 0);
    chk("clr_idx", ARGMAX_IDX, 0);
    launch(1, 0, 4'h0, 64'h0003_0009_0009_0005, 32'h0, 32'h0);
    wait_done(0, lat);
    chk("amx_val_9", int'($signed(ARGMAX_VAL)), 9);
    chk("amx_idx_1", ARGMAX_IDX, 1);
    chk("amx_vld", ARGMAX_VLD, 1);
    pop4(5, 9, 9, 3);

    // clear coincident with the push of -7
    launch(1, 0, 4'hF, 64'hFFF6_FFF7_FFF8_FFF9, 32'h0, 32'h0);
    wait_done(3, lat);
    chk("lat_len1", lat, 7);
    chk("coin_val", int'($signed(ARGMAX_VAL)), -7);
    chk("coin_idx", ARGMAX_IDX, 0);
    chk("coin_vld", ARGMAX_VLD, 1);
    pop4(-7, -8, -9, -10);

    // zero length is rejected
    launch(0, 0, 4'h0, 64'h0, 32'h0, 32'h0);
    chk("err_pulse", ERR_LEN, 1);
    chk("err_busy", BUSY, 0);
    IN_VALID = 1'b0;
    step();
    chk("err_single", ERR_LEN, 0);
    chk("err_no_push", FIFO_LEVEL, 0);

    // START during accumulation is ignored
    launch(2, 0, 4'h0, 64'h0, 32'h01010101, 32'h04030201);
    IN_VALID = 1'b0;
    step();
    CFG_LEN = 10'd1;
    CFG_SHIFT = 5'd3;
    BIAS = 64'h0064_0064_0064_0064;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("ign_ready", IN_READY, 1);
    IN_VALID = 1'b1;
    wait_done(0, lat);
    pop4(2, 4, 6, 8);

    // full FIFO stalls the drain of a second group
    launch(1, 0, 4'h0, 64'h0004_0003_0002_0001, 32'h0, 32'h0);
    wait_done(0, lat);
    launch(1, 0, 4'h0, 64'h0008_0007_0006_0005, 32'h0, 32'h0);
    IN_VALID = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      step();
      seen |= DONE;
    end
    IN_VALID = 1'b0;
    chk("stall_no_done", seen, 0);
    chk("stall_busy", BUSY, 1);
    chk("stall_level", FIFO_LEVEL, 4);
    for (int i = 0; i < 4; i++) begin
      chk("stall_head", OUT_DATA, i + 1);
      OUT_READY = 1'b1;
      step();
      OUT_READY = 1'b0;
      chk("stall_after_pop", FIFO_LEVEL, 3);
      chk("stall_pop_done", DONE, 0);
      step();
      chk("stall_refill", FIFO_LEVEL, 4);
      chk("stall_done", DONE, int'(i == 3));
    end
    chk("stall_idle", BUSY, 0);
    pop4(5, 6, 7, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
